r2sdf_butterfly_stage: RTL
==========================

// Module: r2sdf_butterfly_stage
// PURPOSE
//  Radix-2 single-path delay-feedback (R2SDF) butterfly stage of the FFT datapath.
//  Streams one complex S3.11 sample per valid cycle and pairs x[n] with x[n+DEPTH]
//  through an internal delay line. Emits sums (first half) and differences (second half).
//  Its outputs feed the 4:1 complex selector of the twiddle/reorder stage directly downstream.
// PARAMETERS
//  WL        14  MSB index; sample width is WL+1 = 15 bits, signed S3.11
//  DEPTH     8   delay-line length = half the stage span; must be a power of 2, >= 2
//  LOG_DEPTH 3   log2(DEPTH)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_real/in_imag carry a sample this cycle
//  in_real    in   WL+1   signed input, real part
//  in_imag    in   WL+1   signed input, imaginary part
//  flush      in   1      drain pending differences while in_valid=0
//  out_valid  out  1      out_real/out_imag valid this cycle
//  out_real   out  WL+1   signed output, real part (registered)
//  out_imag   out  WL+1   signed output, imaginary part (registered)
//  out_diff   out  1      0 = output is a sum, 1 = output is a difference (drives downstream select)
// BEHAVIOUR
//  - State: cnt[LOG_DEPTH:0] sample counter, pending flag, DEPTH-entry complex FIFO delay line dl.
//  - An "advance" happens when in_valid=1, or when flush=1 and pending=1 and cnt[LOG_DEPTH]=0.
//    On a flush advance, the input is treated as 0+j0. Nothing changes without an advance
//    (stalls are bubble-free; out_valid drops).
//  - Phase A (cnt[LOG_DEPTH]=0): push the input into dl; pop the oldest dl entry to the output.
//    out_valid=pending, out_diff=1.
//  - Phase B (cnt[LOG_DEPTH]=1): d = popped dl entry, x = input.
//    Output d+x with out_valid=1, out_diff=0. Push d-x into dl.
//  - cnt increments by 1 per advance and wraps from 2*DEPTH-1 to 0.
//  - At the phase-B to phase-A wrap, set pending=1.
//  - On a flush advance at cnt=DEPTH-1, clear pending. Flush advances never set pending.
//  - Arithmetic: sign-extend operands to WL+2 bits, add or subtract, then saturate to
//    [-2^WL, 2^WL-1] (i.e. [-16384, 16383]). Real and imaginary parts are handled independently.
//  - Latency: an output appears on the clock edge that registers the advance.
//    out_* are held when there is no advance.
//  - Reset: cnt=0, pending=0, all dl entries=0, out_valid=0, out_real=0, out_imag=0, out_diff=0.
//    A reset mid-frame discards all partial data; the first sample after reset is treated as n=0.
//  - If in_valid=1 and flush=1 in the same cycle, in_valid wins and flush is ignored.
//  - Differences leave in the order n=0..DEPTH-1. The sum and difference for the same index
//    are exactly one frame phase apart.
// TESTING (DEPTH=8)
//  1) Ramp: after reset, feed 16 samples x[n]=n+j0 back-to-back, then flush=1.
//     -> out_valid is first high on sample 8; sums are 8,10,...,22 (out_diff=0).
//     -> The flush then yields 8 differences of -8 (out_diff=1); pending returns to 0.
//  2) Continuous frames: two frames of x[n]=n, back-to-back.
//     -> Frame-2 phase A outputs frame-1 differences (-8 x8) interleaved with no gaps.
//  3) Saturation: pair (16383,-16384) with (16383,16383).
//     -> Sum = (16383, -1); difference = (0, -16384).
//  4) Gaps: the ramp of scenario 1 with in_valid toggling every other cycle.
//     -> Same output values as scenario 1; out_valid is low on every stall cycle.
//  5) Reset mid-frame: assert rst after sample 11 of a frame.
//     -> All outputs are 0 and out_valid=0 the next cycle; a fresh ramp reproduces scenario 1.
//  6) in_valid=1 together with flush=1 during phase A.
//     -> Behaves exactly like in_valid alone: the input sample is stored, not zero.

Source files
------------

// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: pairs x[n] with x[n+DEPTH]
// through a DEPTH-entry delay line, emitting saturated sums then differences.
module r2sdf_butterfly_stage #(
  parameter int unsigned WL        = 14,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [WL:0]   in_real,
  input  logic signed [WL:0]   in_imag,
  input  logic                 flush,
  output logic                 out_valid,
  output logic signed [WL:0]   out_real,
  output logic signed [WL:0]   out_imag,
  output logic                 out_diff
);

  localparam int unsigned CntW = LOG_DEPTH + 1;
  localparam logic [CntW-1:0] CntHalfLast = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntLast     = CntW'(2 * DEPTH - 1);

  function automatic logic signed [WL:0] sat(input logic [WL+1:0] v);
    if (v[WL+1] != v[WL]) begin
      return v[WL+1] ? {1'b1, {WL{1'b0}}} : {1'b0, {WL{1'b1}}};
    end
    return v[WL:0];
  endfunction

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic signed [WL:0]   dl_re_q [DEPTH];
  logic signed [WL:0]   dl_re_d [DEPTH];
  logic signed [WL:0]   dl_im_q [DEPTH];
  logic signed [WL:0]   dl_im_d [DEPTH];
  logic                 out_valid_q, out_valid_d;
  logic signed [WL:0]   out_real_q, out_real_d;
  logic signed [WL:0]   out_imag_q, out_imag_d;
  logic                 out_diff_q, out_diff_d;

  logic                 advance;
  logic                 phase_b;
  logic signed [WL:0]   x_re, x_im, d_re, d_im;
  logic [WL+1:0]        sum_re, sum_im, dif_re, dif_im;

  always_comb begin
    // in_valid has priority; a flush advance injects 0+j0
    advance = in_valid | (flush & pending_q & ~cnt_q[LOG_DEPTH]);
    phase_b = cnt_q[LOG_DEPTH];
    x_re    = in_valid ? in_real : '0;
    x_im    = in_valid ? in_imag : '0;
    d_re    = dl_re_q[DEPTH-1];
    d_im    = dl_im_q[DEPTH-1];
    sum_re  = {d_re[WL], d_re} + {x_re[WL], x_re};
    sum_im  = {d_im[WL], d_im} + {x_im[WL], x_im};
    dif_re  = {d_re[WL], d_re} - {x_re[WL], x_re};
    dif_im  = {d_im[WL], d_im} - {x_im[WL], x_im};

    cnt_d       = cnt_q;
    pending_d   = pending_q;
    dl_re_d     = dl_re_q;
    dl_im_d     = dl_im_q;
    out_valid_d = 1'b0;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;
    out_diff_d  = out_diff_q;

    if (advance) begin
      cnt_d = cnt_q + CntW'(1);
      for (int i = DEPTH - 1; i > 0; i--) begin
        dl_re_d[i] = dl_re_q[i-1];
        dl_im_d[i] = dl_im_q[i-1];
      end
      if (phase_b) begin
        dl_re_d[0]  = sat(dif_re);
        dl_im_d[0]  = sat(dif_im);
        out_real_d  = sat(sum_re);
        out_imag_d  = sat(sum_im);
        out_valid_d = 1'b1;
        out_diff_d  = 1'b0;
        if (cnt_q == CntLast) pending_d = 1'b1;
      end else begin
        dl_re_d[0]  = x_re;
        dl_im_d[0]  = x_im;
        out_real_d  = d_re;
        out_imag_d  = d_im;
        out_valid_d = pending_q;
        out_diff_d  = 1'b1;
        if (!in_valid && cnt_q == CntHalfLast) pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_diff_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        dl_re_q[i] <= '0;
        dl_im_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      out_diff_q  <= out_diff_d;
      dl_re_q     <= dl_re_d;
      dl_im_q     <= dl_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_diff  = out_diff_q;

endmodule
